// File: rtl/pc_seq_ctrl_if.sv
// ============================================================================
//  Module      : pc_seq_ctrl_if
//  Description : Fetch (IFU) and data (LSU) valid/ready request/response bus
//                between the PC sequencer and the memory-side units.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_seq_ctrl_if;
    logic ifu_req_valid;
    logic ifu_req_ready;
    logic ifu_rsp_valid;
    logic ifu_rsp_err;
    logic lsu_req_valid;
    logic lsu_req_ready;
    logic lsu_rsp_valid;
    logic lsu_rsp_err;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_err,
        output lsu_req_valid,
        input  lsu_req_ready,
        input  lsu_rsp_valid,
        input  lsu_rsp_err
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_err,
        input  lsu_req_valid,
        output lsu_req_ready,
        output lsu_rsp_valid,
        output lsu_rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
// ============================================================================
//  Module      : pc_seq_ctrl
//  Description : Multi-cycle fetch/exec/mem/commit sequencer producing the PC
//                commit strobe and trap redirects. Optional performance
//                counters are enabled by the macro PC_SEQ_PERF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_seq_ctrl #(
    parameter int TIMEOUT_W = 10
`ifdef PC_SEQ_PERF_EN
    ,
    parameter int PERF_W    = 64
`endif
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pc_seq_ctrl_if.master    bus,
    input  wire logic        is_load,
    input  wire logic        is_store,
    input  wire logic        is_halt,
    output logic             inst_latch_en,
    output logic             rf_wen_en,
    output logic             pc_valid,
    output logic             trap_req,
    output logic [3:0]       trap_cause,
    output logic             halted
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycle,
    output logic [PERF_W-1:0] perf_instret
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_EXEC       = 3'd3,
        ST_MEM_REQ    = 3'd4,
        ST_MEM_WAIT   = 3'd5,
        ST_COMMIT     = 3'd6,
        ST_HALT       = 3'd7
    } state_t;

    localparam logic [TIMEOUT_W-1:0] c_WD_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0] c_WD_ONE   = TIMEOUT_W'(1);
    // Last wait cycle index before the counter would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] c_WD_LAST  = TIMEOUT_W'(2**TIMEOUT_W - 2);
    localparam logic [3:0]           c_CAUSE_IF = 4'h1;
    localparam logic [3:0]           c_CAUSE_LD = 4'h5;
    localparam logic [3:0]           c_CAUSE_ST = 4'h7;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TIMEOUT_W-1:0]   r_wd;
    logic                   r_ifu_rsp_valid;
    logic                   r_ifu_rsp_err;
    logic                   r_mem_store;
    logic                   r_trap;
    logic [3:0]             r_trap_cause;
    logic                   w_set_trap;
    logic [3:0]             w_cause;
    logic                   w_in_wait;
    logic                   w_wd_timeout;
    logic                   w_ifu_rsp_take;

    assign w_in_wait    = (r_state == ST_FETCH_WAIT) || (r_state == ST_MEM_WAIT);
    assign w_wd_timeout = (r_wd == c_WD_LAST);

    // The fetch response is registered so inst_latch_en stays a pure state
    // decode; a response on the handshake cycle lands in the first wait cycle.
    assign w_ifu_rsp_take = bus.ifu_rsp_valid &&
                            ((r_state == ST_FETCH_WAIT) ||
                             ((r_state == ST_FETCH_REQ) && bus.ifu_req_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_wd            <= '0;
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rsp_err   <= 1'b0;
            r_mem_store     <= 1'b0;
            r_trap          <= 1'b0;
            r_trap_cause    <= 4'h0;
        end else begin
            r_state         <= w_next_state;
            r_ifu_rsp_valid <= w_ifu_rsp_take;
            r_ifu_rsp_err   <= w_ifu_rsp_take && bus.ifu_rsp_err;
            r_trap          <= w_set_trap;
            r_trap_cause    <= w_cause;
            if (!w_in_wait) begin
                r_wd <= '0;
            end else if (r_wd != c_WD_MAX) begin
                r_wd <= r_wd + c_WD_ONE;
            end
            if (r_state == ST_EXEC) begin
                r_mem_store <= is_store && !is_load;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_set_trap   = 1'b0;
        w_cause      = 4'h0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH_REQ;
            end
            ST_FETCH_REQ: begin
                if (bus.ifu_req_ready) begin
                    w_next_state = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                if (r_ifu_rsp_valid && !r_ifu_rsp_err) begin
                    w_next_state = ST_EXEC;
                end else if (r_ifu_rsp_valid || w_wd_timeout) begin
                    w_next_state = ST_COMMIT;
                    w_set_trap   = 1'b1;
                    w_cause      = c_CAUSE_IF;
                end
            end
            ST_EXEC: begin
                if (is_halt) begin
                    w_next_state = ST_HALT;
                end else if (is_load || is_store) begin
                    w_next_state = ST_MEM_REQ;
                end else begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_MEM_REQ: begin
                if (bus.lsu_req_ready) begin
                    w_next_state = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.lsu_rsp_valid && !bus.lsu_rsp_err) begin
                    w_next_state = ST_COMMIT;
                end else if (bus.lsu_rsp_valid || w_wd_timeout) begin
                    w_next_state = ST_COMMIT;
                    w_set_trap   = 1'b1;
                    w_cause      = r_mem_store ? c_CAUSE_ST : c_CAUSE_LD;
                end
            end
            ST_COMMIT: begin
                w_next_state = ST_FETCH_REQ;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.ifu_req_valid = (r_state == ST_FETCH_REQ);
    assign bus.lsu_req_valid = (r_state == ST_MEM_REQ);
    assign inst_latch_en     = (r_state == ST_FETCH_WAIT) && r_ifu_rsp_valid && !r_ifu_rsp_err;
    assign pc_valid          = (r_state == ST_COMMIT);
    assign trap_req          = (r_state == ST_COMMIT) && r_trap;
    assign trap_cause        = trap_req ? r_trap_cause : 4'h0;
    assign rf_wen_en         = (r_state == ST_COMMIT) && !r_trap && !r_mem_store;
    assign halted            = (r_state == ST_HALT);

`ifdef PC_SEQ_PERF_EN
    localparam logic [PERF_W-1:0] c_PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] r_perf_cycle;
    logic [PERF_W-1:0] r_perf_instret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_cycle   <= '0;
            r_perf_instret <= '0;
        end else begin
            if ((r_state != ST_IDLE) && (r_state != ST_HALT)) begin
                r_perf_cycle <= r_perf_cycle + c_PERF_ONE;
            end
            if ((r_state == ST_COMMIT) && !r_trap) begin
                r_perf_instret <= r_perf_instret + c_PERF_ONE;
            end
        end
    end

    assign perf_cycle   = r_perf_cycle;
    assign perf_instret = r_perf_instret;
`endif

endmodule

`default_nettype wire

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Multi-cycle control FSM for the single-issue core; produces the `valid` strobe that commits the next PC in the PC register block.
- Sequences instruction fetch (IFU), optional load/store (LSU) and register write-back over valid/ready handshakes.
- Raises a trap redirect on bus error or response timeout; the PC block then selects mtvec.

Parameters:
- TIMEOUT_W, 10, width of the response watchdog counter; timeout fires after 2**TIMEOUT_W-1 wait cycles.
- PERF_W, 64, width of the performance counters (Optional Feature only).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-low reset
- ifu_req_valid  output  1  fetch request at current PC
- ifu_req_ready  input  1  IFU accepts request
- ifu_rsp_valid  input  1  instruction returned
- ifu_rsp_err  input  1  fetch bus error, qualified by ifu_rsp_valid
- inst_latch_en  output  1  1-cycle strobe to capture returned instruction
- is_load  input  1  decoded from latched instruction, stable in EXEC
- is_store  input  1  decoded from latched instruction, stable in EXEC
- is_halt  input  1  ebreak decoded, stable in EXEC
- lsu_req_valid  output  1  data access request
- lsu_req_ready  input  1  LSU accepts request
- lsu_rsp_valid  input  1  data access complete
- lsu_rsp_err  input  1  data bus error, qualified by lsu_rsp_valid
- rf_wen_en  output  1  1-cycle write-back enable, gated downstream by decoded rd write
- pc_valid  output  1  1-cycle PC update strobe
- trap_req  output  1  with pc_valid: PC selects mtvec; CSR latches mepc/mcause
- trap_cause  output  4  0x1 fetch fault, 0x5 load fault, 0x7 store fault; 0 when trap_req=0
- halted  output  1  core stopped by ebreak

Behaviour:
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, COMMIT, HALT.
- Reset (rst low, async): state IDLE; all outputs 0; watchdog 0. After rst rises: one cycle in IDLE, then FETCH_REQ.
- FETCH_REQ:
  - ifu_req_valid=1, held until ifu_req_ready; FETCH_WAIT on the handshake cycle.
  - ifu_rsp_valid in the same cycle as the handshake is legal and is treated as arriving in FETCH_WAIT (registered into it).
- FETCH_WAIT:
  - Watchdog increments each cycle.
  - On ifu_rsp_valid with err=0: inst_latch_en=1 that cycle, go to EXEC.
  - On err=1 or watchdog saturation: go to COMMIT with trap cause 0x1; no inst_latch_en.
- EXEC (exactly 1 cycle):
  - is_halt: go to HALT.
  - Else is_load|is_store: go to MEM_REQ.
  - Else: go to COMMIT.
  - is_load and is_store both high is illegal; treated as load.
- MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then MEM_WAIT.
- MEM_WAIT:
  - Watchdog as in FETCH_WAIT.
  - Response err=0: COMMIT, normal.
  - err=1 or timeout: COMMIT with trap (0x5 load / 0x7 store).
- COMMIT (1 cycle):
  - pc_valid=1 always.
  - rf_wen_en=1 only if no trap and not a store.
  - trap_req/trap_cause valid only in this cycle.
  - Next state FETCH_REQ.
- HALT: halted=1, sticky until reset; pc_valid never asserts; bus requests stay 0.
- Watchdog: cleared on entering any WAIT state; saturates, no wrap.
- Responses arriving outside WAIT states are ignored.
- rst mid-transaction: abort immediately to IDLE; no pc_valid; an in-flight response after reset is ignored.
- Minimum latency per non-memory instruction: 5 cycles (FETCH_REQ→COMMIT with 1-cycle ready/response).
- Outputs are decoded from registered state only: no combinational path from any input to any output.

Optional Feature:
- Macro PC_SEQ_PERF_EN.
- Defined: adds outputs perf_cycle[PERF_W] and perf_instret[PERF_W].
  - perf_cycle: +1 each cycle not in IDLE/HALT.
  - perf_instret: +1 on each COMMIT without trap.
  - Both reset to 0 and wrap modulo 2**PERF_W.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- ALU instruction with ready/rsp each after 1 cycle → pc_valid pulses every 5 cycles; rf_wen_en coincident; trap_req=0.
- Load with LSU rsp 3 cycles after accept → pc_valid 1 cycle after lsu_rsp_valid; rf_wen_en=1. Same for store → rf_wen_en=0.
- ifu_rsp_err=1 on first fetch → no inst_latch_en; COMMIT with trap_req=1, trap_cause=0x1.
- TIMEOUT_W=3, IFU never responds → trap 0x1 after 7 wait cycles; next FETCH_REQ follows.
- is_halt in EXEC → halted=1; no further ifu_req_valid or pc_valid for 100 cycles; rst low clears halted.
- rst low during MEM_WAIT, then lsu_rsp_valid=1 after release → ignored; FETCH_REQ 1 cycle after release; perf_instret=0 (PC_SEQ_PERF_EN).
